// File: rtl/datamemory_ls_if.sv
// Request/response bus of datamemory_ls (byte-addressed MIPS data memory).
// Handshake: a request is taken on a rising edge where REQ=1 and READY=1; REQ while READY=0 is dropped, and VALID pulses for one cycle when the access completes (FAULT qualified by VALID).
interface datamemory_ls_if #(
   parameter int ADDR_WIDTH = 10
);
   logic                  REQ;
   logic                  RW_RD;
   logic [1:0]            SIZE;
   logic                  UNSIGNED;
   logic [ADDR_WIDTH-1:0] ADDR;
   logic [31:0]           din;
   logic [31:0]           dout;
   logic                  READY;
   logic                  VALID;
   logic                  FAULT;

   modport master (
      output REQ, RW_RD, SIZE, UNSIGNED, ADDR, din,
      input  dout, READY, VALID, FAULT
   );

   modport slave (
      input  REQ, RW_RD, SIZE, UNSIGNED, ADDR, din,
      output dout, READY, VALID, FAULT
   );
endinterface

// File: rtl/datamemory_ls.sv
// Byte/halfword/word load-store data memory with wait-state handshake.
// Optional misalignment faulting is enabled by defining DMEM_ALIGN_CHECK_EN.
module datamemory_ls #(
   parameter int ADDR_WIDTH  = 10,
   parameter int WAIT_STATES = 0
) (
   input  logic                CLK,
   input  logic                RST,
   datamemory_ls_if.slave      bus,
   output logic [1:0]          dbg_state
);
   localparam int          DEPTH     = 2 ** (ADDR_WIDTH - 2);
   localparam logic [3:0]  WAIT_LAST = 4'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_EXEC = 2'd2
   } state_e;

   state_e                state_q, state_d;
   logic [3:0]            cnt_q, cnt_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [1:0]            size_q, size_d;
   logic                  rw_q, rw_d;
   logic                  uns_q, uns_d;
   logic [31:0]           din_q, din_d;
   logic [31:0]           dout_q, dout_d;
   logic                  valid_q, valid_d;
   logic                  fault_q, fault_d;

   logic [31:0]           mem [DEPTH];
   logic [ADDR_WIDTH-3:0] widx;
   logic [1:0]            lane;
   logic                  fault_c;
   logic                  do_exec;
   logic                  we;
   logic [3:0]            be;
   logic [31:0]           wdata;
   logic [31:0]           rdata;
   logic [7:0]            byte_v;
   logic [15:0]           half_v;
   logic [31:0]           load_v;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         addr_q  <= '0;
         size_q  <= '0;
         rw_q    <= 1'b0;
         uns_q   <= 1'b0;
         din_q   <= '0;
         dout_q  <= '0;
         valid_q <= 1'b0;
         fault_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         size_q  <= size_d;
         rw_q    <= rw_d;
         uns_q   <= uns_d;
         din_q   <= din_d;
         dout_q  <= dout_d;
         valid_q <= valid_d;
         fault_q <= fault_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         S_IDLE: begin
            cnt_d = '0;
            if (bus.REQ) state_d = (WAIT_STATES > 0) ? S_WAIT : S_EXEC;
         end
         S_WAIT: begin
            if (cnt_q == WAIT_LAST) state_d = S_EXEC;
            else                    cnt_d   = cnt_q + 4'd1;
         end
         S_EXEC:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Request fields are latched only at acceptance; later input changes are ignored.
   always_comb begin
      addr_d = addr_q;
      size_d = size_q;
      rw_d   = rw_q;
      uns_d  = uns_q;
      din_d  = din_q;
      if (state_q == S_IDLE && bus.REQ) begin
         addr_d = bus.ADDR;
         size_d = bus.SIZE;
         rw_d   = bus.RW_RD;
         uns_d  = bus.UNSIGNED;
         din_d  = bus.din;
      end
   end

   // Lane select forces alignment; with the check enabled a misaligned access never commits.
   always_comb begin
      widx    = addr_q[ADDR_WIDTH-1:2];
      fault_c = 1'b0;
      case (size_q)
         2'b00:   lane = addr_q[1:0];
         2'b01:   lane = {addr_q[1], 1'b0};
         default: lane = 2'b00;
      endcase
`ifdef DMEM_ALIGN_CHECK_EN
      case (size_q)
         2'b01:   fault_c = addr_q[0];
         2'b10:   fault_c = |addr_q[1:0];
         2'b11:   fault_c = 1'b1;
         default: fault_c = 1'b0;
      endcase
`endif
   end

   always_comb begin
      case (size_q)
         2'b00: begin
            be    = 4'b0001 << lane;
            wdata = {4{din_q[7:0]}};
         end
         2'b01: begin
            be    = 4'b0011 << lane;
            wdata = {2{din_q[15:0]}};
         end
         default: begin
            be    = 4'b1111;
            wdata = din_q;
         end
      endcase
      do_exec = (state_q == S_EXEC);
      we      = do_exec && !rw_q && !fault_c;
   end

   always_comb begin
      rdata  = mem[widx];
      byte_v = rdata[8*lane +: 8];
      half_v = rdata[16*lane[1] +: 16];
      case (size_q)
         2'b00:   load_v = uns_q ? {24'd0, byte_v} : {{24{byte_v[7]}}, byte_v};
         2'b01:   load_v = uns_q ? {16'd0, half_v} : {{16{half_v[15]}}, half_v};
         default: load_v = rdata;
      endcase
      dout_d  = dout_q;
      if (do_exec && rw_q && !fault_c) dout_d = load_v;
      valid_d = do_exec;
      fault_d = do_exec && fault_c;
   end

   always_ff @(posedge CLK) begin
      for (int i = 0; i < 4; i++) begin
         if (we && be[i]) mem[widx][8*i +: 8] <= wdata[8*i +: 8];
      end
   end

   always_comb begin
      bus.READY = (state_q == S_IDLE);
      bus.VALID = valid_q;
      bus.FAULT = fault_q;
      bus.dout  = dout_q;
      dbg_state = state_q;
   end
endmodule
